// File: rtl/mreq_seqn_pkg.sv
// Shared helpers for the MREQ sequencer: index-width sizing for the slave pointer.
package mreq_seqn_pkg;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mreq_seqn_ffs_from.sv
// Combinational search: lowest set bit of vec at or above position from.
module ffs_from
  import mreq_seqn_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  vec,
  input  logic [IW-1:0] from,
  output logic          found_c,
  output logic [IW-1:0] pos_c
);

  // Scan downward so the lowest qualifying bit is the last one written.
  always_comb begin
    found_c = 1'b0;
    pos_c   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (vec[k] && (k >= int'(from))) begin
        found_c = 1'b1;
        pos_c   = IW'(k);
      end
    end
  end

endmodule

// File: rtl/mreq_seqn.sv
// MREQ sequencer: fans one master request out to a masked set of slaves,
// either in index order or all at once, and strobes o_ready on the last handshake.
module mreq_seqn
  import mreq_seqn_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned PARALLEL = 0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_mask,
  output logic [N-1:0] o_valid,
  input  logic [N-1:0] i_ready,
  output logic         o_busy
);

  localparam int unsigned IW = idx_width(N);

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  pending_q, pending_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  valid_q, valid_d;
  logic          busy_q, busy_d;

  logic [N-1:0]  hs;
  logic [N-1:0]  remain;
  logic          acc_found, nxt_found;
  logic [IW-1:0] acc_pos, nxt_pos;

  // Only slaves currently offered a request can complete.
  assign hs     = valid_q & i_ready;
  assign remain = pending_q & ~hs;

  ffs_from #(.N(N), .IW(IW)) u_ffs_acc (
    .vec     (i_mask),
    .from    ('0),
    .found_c (acc_found),
    .pos_c   (acc_pos)
  );

  ffs_from #(.N(N), .IW(IW)) u_ffs_nxt (
    .vec     (remain),
    .from    (idx_q),
    .found_c (nxt_found),
    .pos_c   (nxt_pos)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    idx_d     = idx_q;
    valid_d   = '0;
    o_ready   = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          if (acc_found) begin
            pending_d = i_mask;
            state_d   = SERVE;
            if (PARALLEL == 0) idx_d = acc_pos;
            else               idx_d = '0;
          end else begin
            o_ready = 1'b1;
          end
        end
      end
      SERVE: begin
        pending_d = remain;
        if (PARALLEL != 0) begin
          if (remain == '0) begin
            o_ready = 1'b1;
            state_d = IDLE;
          end
        end else if (|hs) begin
          if (nxt_found) begin
            idx_d = nxt_pos;
          end else begin
            o_ready = 1'b1;
            state_d = IDLE;
            idx_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Request lines are decoded from next state so they leave a flop.
    if (state_d == SERVE) begin
      if (PARALLEL != 0) valid_d = pending_d;
      else               valid_d[idx_d] = pending_d[idx_d];
    end
    busy_d = (state_d == SERVE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      idx_q     <= '0;
      valid_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign o_valid = valid_q;
  assign o_busy  = busy_q;

endmodule
